// File: rtl/gf256_pow_seq.sv
// rtl/gf256_pow_seq.sv - sequential GF(2^8) exponentiator p = a^e, fixed 8-step square-and-multiply
//
// Computes p = a^e over GF(2^8) with reduction polynomial x^8 + POLY (POLY = 8'h63 for the SEED field).
// One exponent bit is consumed per clock, right to left. Every operation takes the same number of
// cycles regardless of e, so that timing reveals nothing about the exponent.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  request, sampled only while idle
//   a      in   8  base operand, captured when start is accepted
//   e      in   8  exponent, captured when start is accepted
//   busy   out  1  high in RUN and DONE
//   done   out  1  one-cycle pulse; p is valid from this cycle on
//   p      out  8  result, held until the next done

module gf256_pow_seq #(
    parameter logic [7:0] POLY = 8'h63
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] e,
    output logic       busy,
    output logic       done,
    output logic [7:0] p
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_next_state;

    logic [7:0] r_acc;
    logic [7:0] r_base;
    logic [7:0] r_exp;
    logic [2:0] r_cnt;
    logic [7:0] r_p;

    logic [7:0] w_m1;
    logic [7:0] w_m2;
    logic [7:0] w_acc_next;

    // Shift-and-add multiply; the running multiplicand is reduced on every shift so the
    // product never leaves 8 bits.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] sum;
        logic [7:0] sh;
        sum = 8'h00;
        sh  = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) begin
                sum = sum ^ sh;
            end
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ POLY) : {sh[6:0], 1'b0};
        end
        return sum;
    endfunction

    assign w_m1       = gf_mul(r_acc, r_base);
    assign w_m2       = gf_mul(r_base, r_base);
    assign w_acc_next = r_exp[0] ? w_m1 : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == 3'd7) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= 8'h00;
            r_base <= 8'h00;
            r_exp  <= 8'h00;
            r_cnt  <= 3'd0;
            r_p    <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc  <= 8'h01;
                        r_base <= a;
                        r_exp  <= e;
                        r_cnt  <= 3'd0;
                    end
                end
                RUN: begin
                    // Squaring runs every step, even after the remaining exponent bits are zero,
                    // to keep the operation constant-time.
                    r_acc  <= w_acc_next;
                    r_base <= w_m2;
                    r_exp  <= {1'b0, r_exp[7:1]};
                    r_cnt  <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_p <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign p = r_p;

endmodule

// File: tb/tb_gf256_pow_seq.sv
// tb/tb_gf256_pow_seq.sv - scoreboard bench for gf256_pow_seq against a repeated-multiply reference

module tb_gf256_pow_seq;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a     = 8'h00;
    logic [7:0] e     = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] p;

    gf256_pow_seq #(.POLY(8'h63)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .e     (e),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [7:0] p;
        int         t0;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: full 15-bit carry-less product, then long division by x^8+x^6+x^5+x+1.
    function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] prod;
        prod = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) prod = prod ^ (16'(x) << i);
        end
        for (int b = 15; b >= 8; b--) begin
            if (prod[b]) prod = prod ^ (16'h0163 << (b - 8));
        end
        return prod[7:0];
    endfunction

    // Reference: a^e as e successive multiplications starting from 1.
    function automatic logic [7:0] ref_pow(input logic [7:0] x, input logic [7:0] n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < int'(n); i++) r = ref_mul(r, x);
        return r;
    endfunction

    // Monitor: every done pulse pops one expectation and checks value and latency.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                check("done_implies_busy", {31'd0, busy}, 32'd1);
                if (prev_done) check("done_one_cycle", 32'd1, 32'd0);
                if (sb.size() == 0) begin
                    check("spurious_done", 32'd1, 32'd0);
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("result_p", {24'd0, p}, {24'd0, x.p});
                    check("latency_edges", cyc - x.t0, 32'd8);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Issue one operation at the first idle opportunity; a/e are scrambled after capture.
    task automatic issue(input logic [7:0] ia, input logic [7:0] ie, input logic expect_ref,
                         input logic [7:0] req);
        exp_t x;
        int   n;
        @(negedge clk);
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd1, 32'd0);
        a     = ia;
        e     = ie;
        start = 1'b1;
        x.p   = ref_pow(ia, ie);
        x.t0  = cyc + 1;
        if (expect_ref) check("ref_model_vector", {24'd0, x.p}, {24'd0, req});
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
        a     = 8'($urandom);
        e     = 8'($urandom);
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0 || busy) begin
            check("done_timeout", 32'd1, 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_p", {24'd0, p}, 32'd0);
        rst_n = 1'b1;

        // Directed vectors: reduction, 4th root, inverse, order, zero cases.
        issue(8'h02, 8'h04, 1'b1, 8'h10);
        wait_drain();
        issue(8'h02, 8'h08, 1'b1, 8'h63);
        issue(8'h10, 8'h40, 1'b1, 8'h02);
        issue(8'h02, 8'hFE, 1'b1, 8'hB1);
        issue(8'h53, 8'hFF, 1'b1, 8'h01);
        issue(8'h00, 8'h00, 1'b1, 8'h01);
        issue(8'h00, 8'h05, 1'b1, 8'h00);
        issue(8'h5A, 8'h00, 1'b1, 8'h01);
        wait_drain();

        // Start held high and re-pulsed during the run: exactly one result, p held until done.
        issue(8'h02, 8'h04, 1'b1, 8'h10);
        wait_drain();
        begin
            exp_t x;
            int   k;
            @(negedge clk);
            a     = 8'h03;
            e     = 8'h02;
            start = 1'b1;
            x.p   = ref_pow(8'h03, 8'h02);
            x.t0  = cyc + 1;
            check("ref_model_3sq", {24'd0, x.p}, 32'h05);
            sb.push_back(x);
            k = 0;
            while (k < 20) begin
                @(negedge clk);
                k++;
                if (done) break;
                check("p_held_old", {24'd0, p}, 32'h10);
                if (k == 3) start = 1'b0;
                if (k == 4) start = 1'b1;
            end
            start = 1'b0;
            if (!done) check("held_start_no_done", 32'd1, 32'd0);
            repeat (12) @(negedge clk);
            check("no_queued_start", {31'd0, busy}, 32'd0);
            check("p_held_new", {24'd0, p}, 32'h05);
            check("sb_empty", sb.size(), 32'd0);
        end

        // Asynchronous reset mid-run aborts without a done.
        issue(8'h37, 8'hA5, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_p", {24'd0, p}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h02, 8'hFE, 1'b1, 8'hB1);
        wait_drain();

        // Random back-to-back operations.
        for (int i = 0; i < 24; i++) begin
            issue(8'($urandom), 8'($urandom), 1'b0, 8'h00);
        end
        wait_drain();
        repeat (3) @(negedge clk);
        check("final_sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
